// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: shifter control codes, shift_op
// encodings and FSM state type.
package shift_sequencer_pkg;

  // Control codes understood by the RegDesloc shifter
  localparam logic [2:0] CtrlNop  = 3'b000;
  localparam logic [2:0] CtrlLoad = 3'b001;
  localparam logic [2:0] CtrlSll  = 3'b010;
  localparam logic [2:0] CtrlSrl  = 3'b011;
  localparam logic [2:0] CtrlSra  = 3'b100;
  localparam logic [2:0] CtrlRor  = 3'b101;
  localparam logic [2:0] CtrlRol  = 3'b110;

  // Requested operation encodings on shift_op; 101..111 are illegal
  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpRor = 3'b011;
  localparam logic [2:0] OpRol = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational map from a requested shift_op to its shifter control code,
// flagging encodings that have no shifter operation.
module shift_op_decode
  import shift_sequencer_pkg::*;
(
  input  logic [2:0] shift_op_i,
  output logic       legal_o,
  output logic [2:0] code_o
);

  always_comb begin
    legal_o = 1'b1;
    code_o  = CtrlNop;
    case (shift_op_i)
      OpSll:   code_o = CtrlSll;
      OpSrl:   code_o = CtrlSrl;
      OpSra:   code_o = CtrlSra;
      OpRor:   code_o = CtrlRor;
      OpRol:   code_o = CtrlRol;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle controller sequencing LOAD then SHIFT on the shared shifter,
// with registered control outputs and done/err pulses for the main control unit.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned AMT_W  = 5,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        shift_op,
  input  logic              amt_sel,
  input  logic [AMT_W-1:0]  shamt_imm,
  input  logic [AMT_W-1:0]  shamt_reg,
  output logic [CTRL_W-1:0] SHIFTER_control,
  output logic              M_SHIFTER,
  output logic [AMT_W-1:0]  amount_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               sel_q, sel_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic [2:0]         code_q, code_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               op_legal;
  logic [2:0]         op_code;
  logic [AMT_W-1:0]   eff_amt;
  logic               can_accept;

  shift_op_decode u_decode (
    .shift_op_i (shift_op),
    .legal_o    (op_legal),
    .code_o     (op_code)
  );

  assign eff_amt    = amt_sel ? shamt_reg : shamt_imm;
  assign can_accept = (state_q == StIdle) || (state_q == StDone);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    amt_d   = amt_q;
    code_d  = code_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle:  state_d = StIdle;
      StLoad:  state_d = (amt_q == '0) ? StDone : StShift;
      StShift: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Requests are only sampled while idle or in the done cycle; otherwise dropped
    if (can_accept && start) begin
      if (op_legal) begin
        sel_d   = amt_sel;
        amt_d   = eff_amt;
        code_d  = op_code;
        state_d = StLoad;
      end else begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
    end

    // Outputs are registered, so they are derived from the next state
    ctrl_d = CTRL_W'(CtrlNop);
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      StLoad: begin
        ctrl_d = CTRL_W'(CtrlLoad);
        busy_d = 1'b1;
      end
      StShift: begin
        ctrl_d = CTRL_W'(code_d);
        busy_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ctrl_q  <= CTRL_W'(CtrlNop);
      sel_q   <= 1'b0;
      amt_q   <= '0;
      code_q  <= CtrlNop;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      sel_q   <= sel_d;
      amt_q   <= amt_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign SHIFTER_control = ctrl_q;
  assign M_SHIFTER       = sel_q;
  assign amount_out      = amt_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a transaction-level model predicts each
// done/err response; a negedge monitor pops and compares them.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] shift_op;
  logic       amt_sel;
  logic [4:0] shamt_imm;
  logic [4:0] shamt_reg;
  logic [2:0] SHIFTER_control;
  logic       M_SHIFTER;
  logic [4:0] amount_out;
  logic       busy;
  logic       done;
  logic       err;

  shift_sequencer #(
    .AMT_W  (5),
    .CTRL_W (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .shift_op        (shift_op),
    .amt_sel         (amt_sel),
    .shamt_imm       (shamt_imm),
    .shamt_reg       (shamt_reg),
    .SHIFTER_control (SHIFTER_control),
    .M_SHIFTER       (M_SHIFTER),
    .amount_out      (amount_out),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    int         edge_n;
    logic [4:0] amt;
    logic       sel;
    logic [2:0] code;
    bit         zero;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         next_free = 0;
  int         last_edge = 0;
  bit         mon_en = 1'b0;
  logic [2:0] ctl_h1 = 3'b000;
  logic [2:0] ctl_h2 = 3'b000;
  logic [2:0] code_tbl [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: pops one expected response per done/err pulse
  always @(negedge clk) begin
    exp_t h;
    if (mon_en) begin
      if (done || err) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {30'd0, done, err}, 32'd0);
        end else begin
          h = q.pop_front();
          chk("out_kind", {31'd0, err}, {31'd0, h.is_err});
          chk("out_edge", cyc, h.edge_n);
          chk("out_busy", {31'd0, busy}, 32'd0);
          chk("out_ctrl_nop", {29'd0, SHIFTER_control}, 32'd0);
          if (!h.is_err) begin
            chk("amount_out", {27'd0, amount_out}, {27'd0, h.amt});
            chk("m_shifter", {31'd0, M_SHIFTER}, {31'd0, h.sel});
            if (h.zero) begin
              chk("ctrl_load_zero", {29'd0, ctl_h1}, 32'd1);
            end else begin
              chk("ctrl_shift", {29'd0, ctl_h1}, {29'd0, h.code});
              chk("ctrl_load", {29'd0, ctl_h2}, 32'd1);
            end
          end
        end
      end else if (q.size() > 0 && cyc > q[0].edge_n) begin
        h = q.pop_front();
        chk("response_timeout", cyc, h.edge_n);
      end
    end
    ctl_h2 = ctl_h1;
    ctl_h1 = SHIFTER_control;
  end

  // Drive one cycle of inputs and feed the transaction-level model
  task automatic drive(input bit st, input logic [2:0] op, input bit sel,
                       input logic [4:0] imm, input logic [4:0] rg);
    exp_t       e;
    int         s;
    logic [4:0] a;
    @(posedge clk);
    #1;
    start = st; shift_op = op; amt_sel = sel; shamt_imm = imm; shamt_reg = rg;
    s = cyc + 1;
    if (st && s >= next_free) begin
      if (op <= 3'd4) begin
        a        = sel ? rg : imm;
        e.is_err = 1'b0;
        e.amt    = a;
        e.sel    = sel;
        e.code   = code_tbl[op];
        e.zero   = (a == 5'd0);
        e.edge_n = s + ((a == 5'd0) ? 1 : 2);
        next_free = e.edge_n + 1;
      end else begin
        e.is_err = 1'b1;
        e.amt    = 5'd0;
        e.sel    = 1'b0;
        e.code   = 3'd0;
        e.zero   = 1'b0;
        e.edge_n = s;
        next_free = s + 1;
      end
      q.push_back(e);
      last_edge = e.edge_n;
    end
  endtask

  // Issue a request at the earliest edge it can be accepted, hammering ignored starts meanwhile
  task automatic issue(input logic [2:0] op, input bit sel, input logic [4:0] imm,
                       input logic [4:0] rg);
    int guard = 0;
    while (cyc + 2 < next_free && guard < 20) begin
      drive(1'b1, 3'd0, 1'b0, 5'd1, 5'd1);
      guard++;
    end
    if (cyc + 1 < next_free) drive(1'b0, 3'd0, 1'b0, 5'd0, 5'd0);
    drive(1'b1, op, sel, imm, rg);
  endtask

  initial begin
    bit saw_done;
    logic [2:0] op;
    reset = 1'b1; start = 1'b0; shift_op = 3'd0; amt_sel = 1'b0;
    shamt_imm = 5'd0; shamt_reg = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {29'd0, SHIFTER_control}, 32'd0);
    chk("rst_msel", {31'd0, M_SHIFTER}, 32'd0);
    chk("rst_amount", {27'd0, amount_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    // Abort an sll mid-SHIFT with reset
    @(posedge clk); #1;
    start = 1'b1; shift_op = 3'd0; amt_sel = 1'b0; shamt_imm = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_load_ctrl", {29'd0, SHIFTER_control}, 32'd1);
    chk("abort_load_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("abort_shift_ctrl", {29'd0, SHIFTER_control}, 32'd2);
    reset = 1'b1;
    #1;
    chk("abort_ctrl", {29'd0, SHIFTER_control}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);

    // Scoreboarded phase: directed cases first, then random traffic
    next_free = cyc + 1;
    mon_en = 1'b1;
    issue(3'd0, 1'b0, 5'd4, 5'd9);    // sll imm 4
    issue(3'd2, 1'b1, 5'd3, 5'd31);   // sra reg 31
    issue(3'd3, 1'b0, 5'd8, 5'd0);    // ror 8, lands in the done cycle
    issue(3'd1, 1'b0, 5'd0, 5'd7);    // srl amount 0
    issue(3'd6, 1'b0, 5'd5, 5'd5);    // illegal
    issue(3'd4, 1'b1, 5'd2, 5'd17);   // rol reg 17
    repeat (3000) begin
      op = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      drive(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31)));
    end
    while (cyc <= last_edge + 2) drive(1'b0, 3'd0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle controller that drives the shared RegDesloc shifter inside the logic unit.
- On a one-cycle start request it latches operation and amount, then issues LOAD followed by SHIFT on the shifter control lines, and pulses done when the shifter output is valid.
- The main control unit issues the request and waits on busy/done before writing the result back.
- Also drives the shift-amount mux select (immediate SHAMT vs. register-sourced amount).

Parameters:
- AMT_W, 5, width of shift amount.
- CTRL_W, 3, width of shifter control code.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE or DONE.
- shift_op  input  3  000 sll, 001 srl, 010 sra, 011 ror, 100 rol; 101–111 illegal.
- amt_sel  input  1  0 = immediate SHAMT, 1 = register amount (rs[4:0]).
- shamt_imm  input  AMT_W  immediate amount.
- shamt_reg  input  AMT_W  register amount.
- SHIFTER_control  output  CTRL_W  code to RegDesloc.
- M_SHIFTER  output  1  amount mux select; equals latched amt_sel while busy.
- amount_out  output  AMT_W  latched effective amount presented to the shifter.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; shifter output valid this cycle.
- err  output  1  one-cycle pulse on an illegal shift_op.

Behaviour:
- Shifter codes (localparams): NOP 000, LOAD 001, SLL 010, SRL 011, SRA 100, ROR 101, ROL 110.
- States: IDLE, LOAD, SHIFT, DONE.
- Reset, asynchronous: state IDLE; SHIFTER_control NOP; M_SHIFTER 0; amount_out 0; busy 0; done 0; err 0. Reset mid-operation aborts the operation with no done pulse.
- IDLE:
  - start with legal op: latch op, amt_sel, and effective amount (mux applied at start); go to LOAD.
  - start with illegal op: err=1 for one cycle; stay IDLE; shifter not touched.
- LOAD: SHIFTER_control=LOAD; busy=1.
  - amount==0: go to DONE (SHIFT skipped).
  - otherwise: go to SHIFT.
- SHIFT: SHIFTER_control = code mapped from latched op; busy=1; go to DONE.
- DONE: SHIFTER_control=NOP; done=1; busy=0.
  - legal start: accepted exactly as in IDLE, go to LOAD (back-to-back issue).
  - illegal start: err, then go to IDLE.
  - no start: go to IDLE.
- Latency from start cycle to done cycle: 3 cycles (amount≠0) or 2 cycles (amount==0).
- Timing rules:
  - All outputs are registered.
  - SHIFTER_control is NOP in every state except LOAD and SHIFT.
  - start in LOAD or SHIFT is ignored (not queued).
  - Inputs shamt_* and amt_sel may change after acceptance without effect.
- Amount 31 is legal; no wrap or saturation is performed here.

Decomposition:
- Shared package: shifter code localparams (NOP…ROL), shift_op encodings, state encoding.
- Natural sub-module: shift_op_decode, a combinational map from shift_op to {legal, shifter code}.
- FSM and latches stay in the top module.

Test Plan:
- Reset then idle: reset=1 asserted mid-SHIFT -> SHIFTER_control=000, busy=0, done never pulses; state IDLE after release.
- Immediate sll: start, shift_op=000, amt_sel=0, shamt_imm=4 -> cycle+1 control 001, amount_out 4, M_SHIFTER 0; cycle+2 control 010; cycle+3 done=1, control 000.
- Register sra: amt_sel=1, shamt_reg=31, shift_op=010 -> control 001 then 100, M_SHIFTER=1, amount_out=31, done at cycle+3.
- Zero amount: shift_op=001, shamt_imm=0 -> control 001 then done at cycle+2; code 011 never issued.
- Illegal op 110 in IDLE -> err pulse same next edge, busy stays 0, control stays 000.
- Back-to-back and collision:
  - start during LOAD/SHIFT -> ignored.
  - start in the DONE cycle (ror, amount 8) -> next cycle LOAD, then 101, done again 3 cycles later.
